// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace monitor: record layout, field widths and FSM state codes.
package cpu_trace_pkg;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] mem;
    logic [FLAG_W-1:0] flags; // {OF,ZF}
  } trace_rec_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HALT = 2'd2;
endpackage

// File: rtl/trace_fifo.sv
// Trace record FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module trace_fifo import cpu_trace_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  trace_rec_t                   rec_i,
  output trace_rec_t                   head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= rec_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/cpu_trace_monitor.sv
// Captures a trace record whenever the CPU PC changes and queues it for a ready/valid consumer.
// Optional halt detection is compiled in with `define TRACE_HALT_DETECT_EN.
module cpu_trace_monitor import cpu_trace_pkg::*; #(
  parameter int DEPTH       = 16,
  parameter int HALT_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                PC,
  input  logic [31:0]                F,
  input  logic [31:0]                Mem,
  input  logic                       ZF,
  input  logic                       OF,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [31:0]                tr_pc,
  output logic [31:0]                tr_f,
  output logic [31:0]                tr_mem,
  output logic [1:0]                 tr_flags,
  output logic [$clog2(DEPTH+1)-1:0] tr_count,
  output logic [15:0]                drop_cnt,
  output logic                       overflow,
  output logic                       halted
);
  trace_rec_t  rec_in, head;
  state_t      state_q, state_d;
  logic [31:0] prev_pc_q;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;
  logic        capture, pop, full, empty, drop;

  assign rec_in = '{pc: PC, f: F, mem: Mem, flags: {OF, ZF}};

`ifdef TRACE_HALT_DETECT_EN
  logic [15:0] halt_cnt_q, halt_cnt_d;
  logic        pc_same;
  assign pc_same = (PC == prev_pc_q);

  always_comb begin
    state_d    = state_q;
    halt_cnt_d = halt_cnt_q;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        capture    = !pc_same;
        halt_cnt_d = pc_same ? halt_cnt_q + 16'd1 : '0;
        if (pc_same && halt_cnt_d == 16'(HALT_CYCLES)) state_d = ST_HALT;
      end
      default: ; // HALT is left only through rst
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) halt_cnt_q <= '0;
    else     halt_cnt_q <= halt_cnt_d;
  end

  assign halted = (state_q == ST_HALT);
`else
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        capture = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN:  capture = (PC != prev_pc_q);
      default: ;
    endcase
  end

  logic unused_halt_cfg;
  assign unused_halt_cfg = ^HALT_CYCLES;
  assign halted = 1'b0;
`endif

  assign tr_valid = !empty;
  assign pop      = tr_valid && tr_ready;
  assign drop     = capture && full && !pop;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_pc_q  <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_pc_q  <= PC;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (capture),
    .pop_i   (pop),
    .rec_i   (rec_in),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (tr_count)
  );

  assign tr_pc    = head.pc;
  assign tr_f     = head.f;
  assign tr_mem   = head.mem;
  assign tr_flags = head.flags;
  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: queue-based reference model checked every cycle plus literal pins.
module tb_cpu_trace_monitor;
  localparam int DEPTH = 16;
  localparam int HC    = 8;
`ifdef TRACE_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] PC = '0, F = '0, Mem = '0;
  logic        ZF = 1'b0, OF = 1'b0, tr_ready = 1'b0;
  logic        tr_valid, overflow, halted;
  logic [31:0] tr_pc, tr_f, tr_mem;
  logic [1:0]  tr_flags;
  logic [4:0]  tr_count;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  cpu_trace_monitor #(.DEPTH(DEPTH), .HALT_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .PC(PC), .F(F), .Mem(Mem), .ZF(ZF), .OF(OF),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_f(tr_f),
    .tr_mem(tr_mem), .tr_flags(tr_flags), .tr_count(tr_count),
    .drop_cnt(drop_cnt), .overflow(overflow), .halted(halted)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records plus the capture/halt rules.
  typedef struct { logic [31:0] pc, f, mem; logic [1:0] fl; } rec_t;
  rec_t        q[$];
  bit          m_live = 0, m_first, m_halt, m_ovf;
  logic [31:0] m_prev;
  int          m_unch, m_drop;

  always @(posedge clk) begin
    bit   pop, push;
    rec_t r;
    if (rst) begin
      q.delete();
      m_live = 1; m_first = 1; m_halt = 0; m_ovf = 0;
      m_prev = '0; m_unch = 0; m_drop = 0;
    end else begin
      pop  = (q.size() > 0) && tr_ready;
      push = !m_halt && (m_first || PC != m_prev);
      if (HALT_EN && !m_first && !m_halt) begin
        m_unch = (PC == m_prev) ? m_unch + 1 : 0;
        if (m_unch == HC) m_halt = 1;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin
          r.pc = PC; r.f = F; r.mem = Mem; r.fl = {OF, ZF};
          q.push_back(r);
        end else begin
          m_ovf = 1;
          if (m_drop < 16'hFFFF) m_drop++;
        end
      end
      m_prev  = PC;
      m_first = 0;
    end
  end

  always @(negedge clk) if (m_live) begin
    chk("valid", 32'(tr_valid), 32'(q.size() > 0));
    chk("count", 32'(tr_count), q.size());
    chk("drop_cnt", 32'(drop_cnt), m_drop);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("halted", 32'(halted), 32'(m_halt));
    if (q.size() > 0) begin
      chk("head_pc", tr_pc, q[0].pc);
      chk("head_f", tr_f, q[0].f);
      chk("head_mem", tr_mem, q[0].mem);
      chk("head_flags", 32'(tr_flags), 32'(q[0].fl));
    end else begin
      chk("idle_pc", tr_pc, 32'h0);
    end
  end

  task automatic drive(input logic [31:0] pc);
    PC = pc; F = pc * 3 + 1; Mem = ~pc; ZF = pc[2]; OF = pc[3];
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; PC = '0; F = '0; Mem = '0; ZF = 1'b0; OF = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset state, then first-cycle capture of PC=0
    do_reset();
    chk("rst_valid", 32'(tr_valid), 0);
    chk("rst_count", 32'(tr_count), 0);
    chk("rst_pc", tr_pc, 0);
    drive(32'h0);
    chk("first_valid", 32'(tr_valid), 1);
    chk("first_count", 32'(tr_count), 1);
    chk("first_f", tr_f, 32'h1);

    // ordering with consumer always ready
    tr_ready = 1'b1;
    drive(32'h4);
    chk("ord_pc4", tr_pc, 32'h4);
    chk("ord_flags4", 32'(tr_flags), 32'h1);
    chk("ord_f4", tr_f, 32'hD);
    drive(32'h8);
    chk("ord_pc8", tr_pc, 32'h8);
    chk("ord_flags8", 32'(tr_flags), 32'h2);
    drive(32'hC);
    chk("ord_pc12", tr_pc, 32'hC);
    chk("ord_flags12", 32'(tr_flags), 32'h3);
    drive(32'hC);
    chk("ord_empty", 32'(tr_valid), 0);
    chk("ord_drops", 32'(drop_cnt), 0);

    // backpressure into a full FIFO
    tr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) drive(32'h100 + 32'(4 * i));
    chk("full_count", 32'(tr_count), 16);
    chk("full_drops", 32'(drop_cnt), 4);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_head", tr_pc, 32'h100);

    // full with simultaneous push and pop
    tr_ready = 1'b1;
    drive(32'h200);
    chk("fpp_count", 32'(tr_count), 16);
    chk("fpp_drops", 32'(drop_cnt), 4);
    chk("fpp_head", tr_pc, 32'h104);
    tr_ready = 1'b0;

    // reset in the middle of operation
    do_reset();
    for (int i = 0; i < 5; i++) drive(32'h300 + 32'(4 * i));
    chk("mid_count5", 32'(tr_count), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_valid", 32'(tr_valid), 0);
    chk("mid_count", 32'(tr_count), 0);
    chk("mid_drops", 32'(drop_cnt), 0);

    // halt detection: PC held at 0x20
    do_reset();
    tr_ready = 1'b1;
    repeat (8) drive(32'h20);
    chk("halt_pre", 32'(halted), 0);
    drive(32'h20);
    chk("halt_set", 32'(halted), 32'(HALT_EN));
    tr_ready = 1'b0;
    drive(32'h40);
    if (HALT_EN) begin
      chk("halt_nocap", 32'(tr_valid), 0);
    end else begin
      chk("run_cap_valid", 32'(tr_valid), 1);
      chk("run_cap_pc", tr_pc, 32'h40);
    end
    drive(32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_trace_monitor.md
CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of 2, 2..256).
REQ-002 SHALL have parameter HALT_CYCLES, default 8, unchanged-PC cycles that flag a halt (used only with TRACE_HALT_DETECT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports PC, F, Mem  input  32 each  CPU program counter, ALU result, memory data.
REQ-006 SHALL have ports ZF, OF  input  1 each  CPU zero and overflow flags.
REQ-007 SHALL have port tr_valid  output  1  trace record available.
REQ-008 SHALL have port tr_ready  input  1  consumer accepts record.
REQ-009 SHALL have ports tr_pc, tr_f, tr_mem  output  32 each  head-record fields.
REQ-010 SHALL have port tr_flags  output  2  head-record {OF,ZF}.
REQ-011 SHALL have port tr_count  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-012 SHALL have port drop_cnt  output  16  records lost to a full FIFO, saturating.
REQ-013 SHALL have port overflow  output  1  sticky; set on first drop.
REQ-014 SHALL have port halted  output  1  CPU halt detected.

Function
REQ-015 SHALL define a capture event as: first cycle after rst deasserts, or any cycle where PC differs from the registered previous PC.
REQ-016 SHALL, on a capture event, push record {PC,F,Mem,OF,ZF} sampled that same cycle; record is visible at outputs no earlier than the next cycle (1-cycle latency into an empty FIFO).
REQ-017 SHALL pop the head record on the cycle tr_valid=1 and tr_ready=1.
REQ-018 SHALL hold tr_valid and all tr_* fields stable while tr_valid=1 and tr_ready=0.
REQ-019 SHALL drive tr_valid=0 when empty; tr_ready while empty SHALL have no effect.
REQ-020 SHALL, when full with a push and no pop, discard the new record, increment drop_cnt (saturate at 16'hFFFF), and set overflow.
REQ-021 SHALL, when full with simultaneous push and pop, accept both; tr_count unchanged, no drop.
REQ-022 SHALL, with simultaneous push and pop on a non-full FIFO, keep tr_count unchanged.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL implement states IDLE (post-reset, awaiting first sample) -> RUN (unconditional after one cycle) -> HALT (only per REQ-029); HALT exits only by rst.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, empty the FIFO, clear drop_cnt, overflow, halted, previous-PC register and halt counter, and enter IDLE.
REQ-026 SHALL drive after reset: tr_valid=0, tr_count=0, drop_cnt=0, overflow=0, halted=0, tr_pc/tr_f/tr_mem=0, tr_flags=0.
REQ-027 SHALL, if rst asserts while a record is pending, discard it with no handshake completion.

Configuration
REQ-028 SHALL compile halt detection only when macro TRACE_HALT_DETECT_EN is defined.
REQ-029 SHALL, with TRACE_HALT_DETECT_EN, count consecutive RUN cycles with PC unchanged; at HALT_CYCLES set halted=1, enter HALT, stop capturing; FIFO drain continues.
REQ-030 SHALL, without TRACE_HALT_DETECT_EN, tie halted to 0, omit the counter and HALT state, capture indefinitely.

Structure
REQ-031 SHALL place trace record typedef (pc, f, mem, flags), field widths and state enum in package cpu_trace_pkg.
REQ-032 SHALL implement storage as sub-module trace_fifo (parameter DEPTH, push/pop/full/empty/count); capture, drop and halt logic stay in cpu_trace_monitor.

Verification
REQ-033 SHALL test reset: rst high 2 cycles, PC=0 -> first post-reset cycle pushes {PC=0}; tr_valid=1 next cycle, tr_count=1.
REQ-034 SHALL test ordering: PC 0,4,8,12 one per cycle, tr_ready=1 -> records out in order 0,4,8,12 with matching F/Mem/flags, no drops.
REQ-035 SHALL test backpressure/full: DEPTH=16, tr_ready=0, 20 distinct PCs -> tr_count=16, drop_cnt=4, overflow=1, head PC=first captured value.
REQ-036 SHALL test full with simultaneous push and pop: FIFO full, tr_ready=1, new PC -> tr_count stays 16, drop_cnt unchanged.
REQ-037 SHALL test halt (macro defined, HALT_CYCLES=8): PC held at 0x20 -> halted=1 on the 8th unchanged cycle; later PC change produces no record.
REQ-038 SHALL test mid-operation reset: 5 records queued, rst pulse -> tr_valid=0, tr_count=0, drop_cnt=0 the next cycle.
